// File: rtl/mips_trace_buffer_pkg.sv
// mips_trace_pkg
//   Shared definitions for the MIPS trace buffer: the capture FSM state
//   encoding, the packed trace record layout and a helper that builds a
//   record from the probe values.
package mips_trace_pkg;

  localparam int DATA_W  = 32;

  // Record layout, MSB to LSB: {pc, instr, mem_we, mem_addr, mem_wd}
  localparam int TRACE_W   = 129;
  localparam int DATA_LSB  = 0;
  localparam int ADDR_LSB  = 32;
  localparam int WE_BIT    = 64;
  localparam int INSTR_LSB = 65;
  localparam int PC_LSB    = 97;

  typedef enum logic [1:0] {
    TR_IDLE    = 2'd0,
    TR_ARMED   = 2'd1,
    TR_CAPTURE = 2'd2,
    TR_DONE    = 2'd3
  } tr_state_e;

  function automatic logic [TRACE_W-1:0] pack_record(
    input logic [DATA_W-1:0] pc,
    input logic [DATA_W-1:0] instr,
    input logic              we,
    input logic [DATA_W-1:0] addr,
    input logic [DATA_W-1:0] wd
  );
    return {pc, instr, we, addr, wd};
  endfunction

endpackage

// File: rtl/mips_trace_buffer_if.sv
// mips_trace_buffer_if
//   Bundles the per-cycle debug-core probes with the host read port.
//   slave  : the trace buffer (samples probes and rd_ready, drives rd_*)
//   master : the probe source / host side (drives probes and rd_ready)
interface mips_trace_buffer_if;
  import mips_trace_pkg::*;

  // probes from the debug core
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] instr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;

  // first-word-fall-through read port
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_pc;
  logic [DATA_W-1:0] rd_instr;
  logic              rd_we;
  logic [DATA_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport slave (
    input  pc, instr, mem_we, mem_addr, mem_wd, rd_ready,
    output rd_valid, rd_pc, rd_instr, rd_we, rd_addr, rd_data
  );

  modport master (
    output pc, instr, mem_we, mem_addr, mem_wd, rd_ready,
    input  rd_valid, rd_pc, rd_instr, rd_we, rd_addr, rd_data
  );

endinterface

// File: rtl/mips_trace_buffer_trace_fifo.sv
// trace_fifo
//   Synchronous first-word-fall-through FIFO, async active-low reset.
//   clk, rst      : clock, asynchronous active-low reset
//   flush         : empty the FIFO on the next edge (wins over push/pop)
//   push, din     : write request and data; ignored when full unless a pop
//                   happens in the same cycle
//   pop           : consume the head entry; ignored when empty
//   dout          : head entry, forced to zero while empty
//   full, empty   : occupancy flags
//   count         : occupancy, 0..DEPTH
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 129
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale contents are hidden by the empty mask.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign dout = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer
//   Debug trace stage: arms on host request, triggers when the fetch PC hits
//   trig_pc, and records qualifying cycles into a FWFT FIFO drained by the host.
//   clk, rst            : clock, asynchronous active-low reset
//   arm, stop           : 1-cycle host pulses (arm flushes and wins over stop)
//   trig_pc, filter_mem : trigger address; capture stores only when set
//   bus (slave)         : probes in, rd_valid/rd_ready read port out
//   state, count        : FSM state, FIFO occupancy
//   overflow, drop_cnt  : sticky drop flag and saturating drop counter
module mips_trace_buffer
  import mips_trace_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter bit STOP_ON_FULL = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic                    stop,
  input  logic [DATA_W-1:0]       trig_pc,
  input  logic                    filter_mem,
  mips_trace_buffer_if.slave      bus,
  output logic [1:0]              state,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [15:0]             drop_cnt
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  tr_state_e        state_q, state_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic             qual, trig_hit;
  logic             push, pop, flush;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [TRACE_W-1:0] rec_in, rec_out;

  assign qual     = filter_mem ? bus.mem_we : 1'b1;
  assign trig_hit = (bus.pc == trig_pc);
  assign pop      = !fifo_empty && bus.rd_ready;
  assign rec_in   = pack_record(bus.pc, bus.instr, bus.mem_we, bus.mem_addr, bus.mem_wd);

  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    push       = 1'b0;
    flush      = 1'b0;
    if (arm) begin
      state_d    = TR_ARMED;
      flush      = 1'b1;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (stop) begin
      state_d = TR_IDLE;
    end else begin
      case (state_q)
        TR_ARMED: begin
          // The trigger cycle itself is recorded when it qualifies.
          if (trig_hit) begin
            state_d = TR_CAPTURE;
            push    = qual;
          end
        end
        TR_CAPTURE: push = qual;
        default:    ;
      endcase
      if (push && fifo_full && !pop) begin
        // No room and nothing leaving: the record is lost.
        overflow_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end else if (STOP_ON_FULL && push && !pop && fifo_count == LAST_CNT) begin
        // Only a net-growing push can fill the FIFO; push+pop keeps capturing.
        state_d = TR_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= TR_IDLE;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TRACE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .din   (rec_in),
    .pop   (pop),
    .dout  (rec_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // rec_out is already zero while empty, so rd_* read zero then.
  assign bus.rd_valid = !fifo_empty;
  assign bus.rd_pc    = rec_out[PC_LSB    +: DATA_W];
  assign bus.rd_instr = rec_out[INSTR_LSB +: DATA_W];
  assign bus.rd_we    = rec_out[WE_BIT];
  assign bus.rd_addr  = rec_out[ADDR_LSB  +: DATA_W];
  assign bus.rd_data  = rec_out[DATA_LSB  +: DATA_W];

  assign state    = state_q;
  assign count    = fifo_count;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_mips_trace_buffer.sv
module tb_mips_trace_buffer;
  import mips_trace_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arm = 1'b0, stop = 1'b0, filter_mem = 1'b0;
  logic [31:0] trig_pc = 32'h0;
  logic [31:0] pc = 32'h0, mem_addr = 32'h0, mem_wd = 32'h0;
  logic        mem_we = 1'b0, rd_ready = 1'b0;

  logic [1:0]  state1, state0;
  logic [4:0]  count1, count0;
  logic        ovf1, ovf0;
  logic [15:0] drop1, drop0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // dut1 stops when full, dut0 keeps capturing and counts drops.
  mips_trace_buffer_if bus1();
  mips_trace_buffer_if bus0();

  assign bus1.pc = pc;  assign bus1.instr = pc ^ 32'h2400_0000;
  assign bus1.mem_we = mem_we; assign bus1.mem_addr = mem_addr;
  assign bus1.mem_wd = mem_wd; assign bus1.rd_ready = rd_ready;
  assign bus0.pc = pc;  assign bus0.instr = pc ^ 32'h2400_0000;
  assign bus0.mem_we = mem_we; assign bus0.mem_addr = mem_addr;
  assign bus0.mem_wd = mem_wd; assign bus0.rd_ready = rd_ready;

  mips_trace_buffer #(.DEPTH(16), .STOP_ON_FULL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .trig_pc(trig_pc),
    .filter_mem(filter_mem), .bus(bus1), .state(state1), .count(count1),
    .overflow(ovf1), .drop_cnt(drop1)
  );

  mips_trace_buffer #(.DEPTH(16), .STOP_ON_FULL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .trig_pc(trig_pc),
    .filter_mem(filter_mem), .bus(bus0), .state(state0), .count(count0),
    .overflow(ovf0), .drop_cnt(drop0)
  );

  typedef struct {
    logic        arm;
    logic [31:0] pc;
    logic [1:0]  st1;
    logic [4:0]  cnt1;
    logic [1:0]  st0;
    logic [4:0]  cnt0;
    logic        ovf0;
    logic [15:0] drop0;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic a, input logic [31:0] p,
                              input logic [1:0] s1, input int c1,
                              input logic [1:0] s0, input int c0,
                              input logic o0, input int d0);
    vec_t v;
    v.arm = a; v.pc = p; v.st1 = s1; v.cnt1 = 5'(c1);
    v.st0 = s0; v.cnt0 = 5'(c0); v.ovf0 = o0; v.drop0 = 16'(d0);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // arm, pc, st1, cnt1, st0, cnt0, ovf0, drop0  (trig_pc = 0x10)
    vecs[0]  = mk(1, 32'h100, TR_ARMED,   0, TR_ARMED,   0, 0, 0);
    vecs[1]  = mk(0, 32'h000, TR_ARMED,   0, TR_ARMED,   0, 0, 0);
    vecs[2]  = mk(0, 32'h004, TR_ARMED,   0, TR_ARMED,   0, 0, 0);
    vecs[3]  = mk(0, 32'h008, TR_ARMED,   0, TR_ARMED,   0, 0, 0);
    vecs[4]  = mk(0, 32'h00C, TR_ARMED,   0, TR_ARMED,   0, 0, 0);
    vecs[5]  = mk(0, 32'h010, TR_CAPTURE, 1, TR_CAPTURE, 1, 0, 0);
    vecs[6]  = mk(0, 32'h014, TR_CAPTURE, 2, TR_CAPTURE, 2, 0, 0);
    vecs[7]  = mk(0, 32'h018, TR_CAPTURE, 3, TR_CAPTURE, 3, 0, 0);
    vecs[8]  = mk(0, 32'h01C, TR_CAPTURE, 4, TR_CAPTURE, 4, 0, 0);
    vecs[9]  = mk(0, 32'h020, TR_CAPTURE, 5, TR_CAPTURE, 5, 0, 0);
    vecs[10] = mk(0, 32'h024, TR_CAPTURE, 6, TR_CAPTURE, 6, 0, 0);
    vecs[11] = mk(0, 32'h028, TR_CAPTURE, 7, TR_CAPTURE, 7, 0, 0);
    vecs[12] = mk(0, 32'h02C, TR_CAPTURE, 8, TR_CAPTURE, 8, 0, 0);
    vecs[13] = mk(0, 32'h030, TR_CAPTURE, 9, TR_CAPTURE, 9, 0, 0);
    vecs[14] = mk(0, 32'h034, TR_CAPTURE, 10, TR_CAPTURE, 10, 0, 0);
    vecs[15] = mk(0, 32'h038, TR_CAPTURE, 11, TR_CAPTURE, 11, 0, 0);
    vecs[16] = mk(0, 32'h03C, TR_CAPTURE, 12, TR_CAPTURE, 12, 0, 0);
    vecs[17] = mk(0, 32'h040, TR_CAPTURE, 13, TR_CAPTURE, 13, 0, 0);
    vecs[18] = mk(0, 32'h044, TR_CAPTURE, 14, TR_CAPTURE, 14, 0, 0);
    vecs[19] = mk(0, 32'h048, TR_CAPTURE, 15, TR_CAPTURE, 15, 0, 0);
    vecs[20] = mk(0, 32'h04C, TR_DONE,    16, TR_CAPTURE, 16, 0, 0);
    vecs[21] = mk(0, 32'h050, TR_DONE,    16, TR_CAPTURE, 16, 1, 1);
    vecs[22] = mk(0, 32'h054, TR_DONE,    16, TR_CAPTURE, 16, 1, 2);
    vecs[23] = mk(0, 32'h058, TR_DONE,    16, TR_CAPTURE, 16, 1, 3);
    vecs[24] = mk(0, 32'h05C, TR_DONE,    16, TR_CAPTURE, 16, 1, 4);

    // reset state
    #2;
    chk("rst_state1", 32'(state1), 0);
    chk("rst_count1", 32'(count1), 0);
    chk("rst_valid1", 32'(bus1.rd_valid), 0);
    chk("rst_rdpc1",  bus1.rd_pc, 0);
    chk("rst_ovf0",   32'(ovf0), 0);
    chk("rst_drop0",  32'(drop0), 0);
    @(negedge clk);
    rst = 1'b1;
    trig_pc = 32'h10;

    // trigger / fill / overflow table
    for (int i = 0; i < 25; i++) begin
      arm = vecs[i].arm;
      pc  = vecs[i].pc;
      step();
      arm = 1'b0;
      chk($sformatf("v%0d_st1", i),  32'(state1), 32'(vecs[i].st1));
      chk($sformatf("v%0d_cnt1", i), 32'(count1), 32'(vecs[i].cnt1));
      chk($sformatf("v%0d_st0", i),  32'(state0), 32'(vecs[i].st0));
      chk($sformatf("v%0d_cnt0", i), 32'(count0), 32'(vecs[i].cnt0));
      chk($sformatf("v%0d_ovf0", i), 32'(ovf0),   32'(vecs[i].ovf0));
      chk($sformatf("v%0d_drp0", i), 32'(drop0),  32'(vecs[i].drop0));
    end
    chk("head_valid1", 32'(bus1.rd_valid), 1);
    chk("head_pc1",    bus1.rd_pc, 32'h10);
    chk("head_instr1", bus1.rd_instr, 32'h2400_0010);
    chk("head_pc0",    bus0.rd_pc, 32'h10);
    chk("ovf1",        32'(ovf1), 0);
    chk("drop1",       32'(drop1), 0);

    // drain with rd_ready held; dut0 stays full and keeps capturing
    rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) begin
        chk($sformatf("drain%0d_pc1", i), bus1.rd_pc, 32'h10 + 32'(4 * i));
        chk($sformatf("drain%0d_pc0", i), bus0.rd_pc, 32'h10 + 32'(4 * i));
      end else begin
        chk($sformatf("drain%0d_v1", i),  32'(bus1.rd_valid), 0);
        chk($sformatf("drain%0d_pc0", i), bus0.rd_pc, 32'h200 + 32'(4 * (i - 16)));
      end
      pc = 32'h200 + 32'(4 * i);
      step();
      chk($sformatf("drain%0d_cnt0", i), 32'(count0), 16);
    end
    chk("drain_drop0", 32'(drop0), 4);
    chk("drain_cnt1",  32'(count1), 0);
    rd_ready = 1'b0;

    // filter: trigger on a non-store, then only the store is kept
    arm = 1'b1; filter_mem = 1'b1; trig_pc = 32'h18; pc = 32'h0;
    step();
    arm = 1'b0;
    chk("farm_st1",   32'(state1), 32'(TR_ARMED));
    chk("farm_cnt0",  32'(count0), 0);
    chk("farm_drop0", 32'(drop0), 0);
    chk("farm_ovf0",  32'(ovf0), 0);
    pc = 32'h18; step();
    chk("ftrig_st1",  32'(state1), 32'(TR_CAPTURE));
    chk("ftrig_cnt1", 32'(count1), 0);
    pc = 32'h1C; step();
    pc = 32'h20; mem_we = 1'b1; mem_addr = 32'h100; mem_wd = 32'hDEAD_BEEF; step();
    pc = 32'h24; mem_we = 1'b0; mem_addr = 32'h104; mem_wd = 32'h0; step();
    chk("f_cnt1",   32'(count1), 1);
    chk("f_cnt0",   32'(count0), 1);
    chk("f_pc1",    bus1.rd_pc, 32'h20);
    chk("f_instr1", bus1.rd_instr, 32'h2400_0020);
    chk("f_we1",    32'(bus1.rd_we), 1);
    chk("f_addr1",  bus1.rd_addr, 32'h100);
    chk("f_data1",  bus1.rd_data, 32'hDEAD_BEEF);
    chk("f_we0",    32'(bus0.rd_we), 1);
    chk("f_addr0",  bus0.rd_addr, 32'h100);
    chk("f_data0",  bus0.rd_data, 32'hDEAD_BEEF);

    // second store, then stop during CAPTURE
    pc = 32'h30; mem_we = 1'b1; mem_addr = 32'h104; mem_wd = 32'h1234_5678; step();
    chk("s_cnt1",    32'(count1), 2);
    chk("s_stable1", bus1.rd_data, 32'hDEAD_BEEF);
    stop = 1'b1; pc = 32'h34; step();
    stop = 1'b0;
    chk("stop_st1",  32'(state1), 32'(TR_IDLE));
    chk("stop_cnt1", 32'(count1), 2);
    pc = 32'h38; step();
    chk("idle_cnt1", 32'(count1), 2);
    mem_we = 1'b0;
    rd_ready = 1'b1;
    chk("sd_pc1", bus1.rd_pc, 32'h20);
    step();
    chk("sd_pc1b",   bus1.rd_pc, 32'h30);
    chk("sd_addr1b", bus1.rd_addr, 32'h104);
    chk("sd_data1b", bus1.rd_data, 32'h1234_5678);
    step();
    chk("sd_valid1", 32'(bus1.rd_valid), 0);
    chk("sd_cnt0",   32'(count0), 0);
    rd_ready = 1'b0;

    // fill again, then arm+stop together while DONE (arm wins)
    arm = 1'b1; filter_mem = 1'b0; trig_pc = 32'h0; pc = 32'h40;
    step();
    arm = 1'b0;
    for (int k = 0; k < 18; k++) begin
      pc = 32'(4 * k);
      step();
    end
    chk("ra_st1",   32'(state1), 32'(TR_DONE));
    chk("ra_cnt1",  32'(count1), 16);
    chk("ra_st0",   32'(state0), 32'(TR_CAPTURE));
    chk("ra_drop0", 32'(drop0), 2);
    chk("ra_ovf0",  32'(ovf0), 1);
    arm = 1'b1; stop = 1'b1; pc = 32'h40;
    step();
    arm = 1'b0; stop = 1'b0;
    chk("as_st1",    32'(state1), 32'(TR_ARMED));
    chk("as_cnt1",   32'(count1), 0);
    chk("as_valid1", 32'(bus1.rd_valid), 0);
    chk("as_cnt0",   32'(count0), 0);
    chk("as_drop0",  32'(drop0), 0);
    chk("as_ovf0",   32'(ovf0), 0);

    // asynchronous reset mid-capture with 7 entries
    for (int k = 0; k < 7; k++) begin
      pc = 32'(4 * k);
      step();
    end
    chk("mr_cnt1", 32'(count1), 7);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_st1",    32'(state1), 32'(TR_IDLE));
    chk("ar_valid1", 32'(bus1.rd_valid), 0);
    chk("ar_cnt1",   32'(count1), 0);
    chk("ar_cnt0",   32'(count0), 0);
    chk("ar_ovf0",   32'(ovf0), 0);
    @(negedge clk);
    rst = 1'b1;
    pc = 32'h0;
    step();
    chk("post_st1", 32'(state1), 32'(TR_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
